// File: rtl/cnn_pkg.sv
// Shared types and helpers for the cnn_core controllers.
package cnn_pkg;

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StLoadW = 3'd1,
    StRun   = 3'd2,
    StDrain = 3'd3,
    StDone  = 3'd4
  } state_e;

  localparam int unsigned K_LAT_DEF = 2;

  // Counter/index width that never collapses to zero bits.
  function automatic int unsigned clog2_min1(input int unsigned v);
    return (v <= 1) ? 1 : $clog2(v);
  endfunction

endpackage

// File: rtl/cnn_conv_ctrl_if.sv
// Weight, window, kernel and output-buffer handshakes of the conv sequencer.
interface cnn_conv_ctrl_if #(
  parameter int unsigned CH_BW = 2,
  parameter int unsigned R_BW  = 3,
  parameter int unsigned C_BW  = 3,
  parameter int unsigned OA_BW = 8
);
  logic             o_w_req;
  logic [CH_BW-1:0] o_w_ch;
  logic             i_w_ack;
  logic             o_win_req;
  logic [R_BW-1:0]  o_win_row;
  logic [C_BW-1:0]  o_win_col;
  logic             i_win_ack;
  logic             o_k_valid;
  logic             i_k_valid;
  logic             o_wr_en;
  logic [OA_BW-1:0] o_wr_addr;

  modport master (
    output o_w_req, o_w_ch, o_win_req, o_win_row, o_win_col, o_k_valid, o_wr_en, o_wr_addr,
    input  i_w_ack, i_win_ack, i_k_valid
  );

  modport slave (
    input  o_w_req, o_w_ch, o_win_req, o_win_row, o_win_col, o_k_valid, o_wr_en, o_wr_addr,
    output i_w_ack, i_win_ack, i_k_valid
  );
endinterface

// File: rtl/cnn_pos_counter.sv
// Row/column raster counter: column advances on i_inc, wraps into the next row.
module cnn_pos_counter
  import cnn_pkg::*;
#(
  parameter int unsigned NR = 3,
  parameter int unsigned NC = 3,
  localparam int unsigned RW = clog2_min1(NR),
  localparam int unsigned CW = clog2_min1(NC)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_clr,
  input  logic          i_inc,
  output logic [RW-1:0] o_row,
  output logic [CW-1:0] o_col,
  output logic          o_last
);

  localparam logic [RW-1:0] ROW_LAST = RW'(NR - 1);
  localparam logic [CW-1:0] COL_LAST = CW'(NC - 1);

  logic [RW-1:0] r_row;
  logic [CW-1:0] r_col;
  logic          w_row_last;
  logic          w_col_last;

  assign w_row_last = (r_row == ROW_LAST);
  assign w_col_last = (r_col == COL_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_row <= '0;
      r_col <= '0;
    end else if (i_clr) begin
      r_row <= '0;
      r_col <= '0;
    end else if (i_inc) begin
      if (w_col_last) begin
        r_col <= '0;
        r_row <= w_row_last ? '0 : r_row + RW'(1);
      end else begin
        r_col <= r_col + CW'(1);
      end
    end
  end

  assign o_row  = r_row;
  assign o_col  = r_col;
  assign o_last = w_row_last & w_col_last;

endmodule

// File: rtl/cnn_conv_ctrl.sv
// Conv sequencer: per output channel loads weights, issues every valid window,
// then drains the kernel before moving on; tracks output-buffer write addresses.
module cnn_conv_ctrl
  import cnn_pkg::*;
#(
  parameter int unsigned IW    = 8,
  parameter int unsigned IH    = 8,
  parameter int unsigned KW    = 3,
  parameter int unsigned KH    = 3,
  parameter int unsigned OCH   = 4,
  parameter int unsigned K_LAT = K_LAT_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_start,
  output logic            o_busy,
  output logic            o_done,
  cnn_conv_ctrl_if.master io_bus
);

  localparam int unsigned OW    = IW - KW + 1;
  localparam int unsigned OH    = IH - KH + 1;
  localparam int unsigned NPOS  = OW * OH;
  localparam int unsigned NOUT  = NPOS * OCH;
  localparam int unsigned OA_BW = clog2_min1(NOUT);
  localparam int unsigned CH_BW = clog2_min1(OCH);
  localparam int unsigned R_BW  = clog2_min1(OH);
  localparam int unsigned C_BW  = clog2_min1(OW);
  localparam int unsigned F_BW  = clog2_min1(K_LAT + 1);

  localparam logic [CH_BW-1:0] CH_LAST = CH_BW'(OCH - 1);
  localparam logic [OA_BW-1:0] NPOS_A  = OA_BW'(NPOS);
  localparam logic [OA_BW-1:0] OW_A    = OA_BW'(OW);

  state_e           r_state, w_state_nxt;
  logic [CH_BW-1:0] r_ch, r_wr_ch;
  logic [F_BW-1:0]  r_infl;
  logic             w_start_acc, w_win_req, w_iss, w_iss_last;
  logic             w_wr_inc, w_wr_last, w_ch_wr_done, w_ch_adv;
  logic [R_BW-1:0]  w_iss_row, w_wr_row;
  logic [C_BW-1:0]  w_iss_col, w_wr_col;

  assign w_start_acc = (r_state == StIdle) & i_start;
  // A write in the same cycle frees a slot, so a full pipe still issues back-to-back.
  assign w_win_req   = (r_state == StRun) & ((r_infl < F_BW'(K_LAT)) | io_bus.i_k_valid);
  assign w_iss       = w_win_req & io_bus.i_win_ack;
  assign w_wr_inc    = io_bus.i_k_valid & ((r_state == StRun) | (r_state == StDrain));
  // Write side already rolled over means the channel finished before DRAIN was reached.
  assign w_ch_wr_done = (w_wr_inc & w_wr_last) | (r_wr_ch != r_ch);
  assign w_ch_adv     = (r_state == StDrain) & w_ch_wr_done & (r_ch != CH_LAST);

  cnn_pos_counter #(.NR(OH), .NC(OW)) u_iss_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .i_clr (w_start_acc),
    .i_inc (w_iss),
    .o_row (w_iss_row),
    .o_col (w_iss_col),
    .o_last(w_iss_last)
  );

  cnn_pos_counter #(.NR(OH), .NC(OW)) u_wr_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .i_clr (w_start_acc),
    .i_inc (w_wr_inc),
    .o_row (w_wr_row),
    .o_col (w_wr_col),
    .o_last(w_wr_last)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StIdle;
      r_ch    <= '0;
      r_wr_ch <= '0;
      r_infl  <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_start_acc) begin
        r_ch    <= '0;
        r_wr_ch <= '0;
        r_infl  <= '0;
      end else begin
        if (w_ch_adv) r_ch <= r_ch + CH_BW'(1);
        if (w_wr_inc && w_wr_last) r_wr_ch <= r_wr_ch + CH_BW'(1);
        if (w_iss && !w_wr_inc) begin
          r_infl <= r_infl + F_BW'(1);
        end else if (!w_iss && w_wr_inc && (r_infl != '0)) begin
          r_infl <= r_infl - F_BW'(1);
        end
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      StIdle:  if (i_start) w_state_nxt = StLoadW;
      StLoadW: if (io_bus.i_w_ack) w_state_nxt = StRun;
      StRun:   if (w_iss && w_iss_last) w_state_nxt = StDrain;
      StDrain: if (w_ch_wr_done) w_state_nxt = (r_ch == CH_LAST) ? StDone : StLoadW;
      StDone:  w_state_nxt = StIdle;
      default: w_state_nxt = StIdle;
    endcase
  end

  assign o_busy           = (r_state != StIdle);
  assign o_done           = (r_state == StDone);
  assign io_bus.o_w_req   = (r_state == StLoadW);
  assign io_bus.o_w_ch    = r_ch;
  assign io_bus.o_win_req = w_win_req;
  assign io_bus.o_win_row = w_iss_row;
  assign io_bus.o_win_col = w_iss_col;
  assign io_bus.o_k_valid = w_iss;
  assign io_bus.o_wr_en   = w_wr_inc;
  assign io_bus.o_wr_addr = OA_BW'(r_wr_ch) * NPOS_A + OA_BW'(w_wr_row) * OW_A
                          + OA_BW'(w_wr_col);

endmodule

// File: tb/tb_cnn_conv_ctrl.sv
// Scoreboard bench for cnn_conv_ctrl: a 5x5/2-channel instance and a 3x3/1-channel instance.
module tb_cnn_conv_ctrl;
  import cnn_pkg::*;

  localparam int unsigned A_CH = clog2_min1(2);
  localparam int unsigned A_R  = clog2_min1(3);
  localparam int unsigned A_C  = clog2_min1(3);
  localparam int unsigned A_OA = clog2_min1(18);

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic a_start = 1'b0, b_start = 1'b0;
  logic a_busy, a_done, b_busy, b_done;

  always #5 clk = ~clk;

  cnn_conv_ctrl_if #(.CH_BW(A_CH), .R_BW(A_R), .C_BW(A_C), .OA_BW(A_OA)) a_if ();
  cnn_conv_ctrl_if #(.CH_BW(1), .R_BW(1), .C_BW(1), .OA_BW(1)) b_if ();

  cnn_conv_ctrl #(.IW(5), .IH(5), .KW(3), .KH(3), .OCH(2), .K_LAT(2)) u_a (
    .clk(clk), .rst_n(rst_n), .i_start(a_start), .o_busy(a_busy), .o_done(a_done),
    .io_bus(a_if)
  );

  cnn_conv_ctrl #(.IW(3), .IH(3), .KW(3), .KH(3), .OCH(1), .K_LAT(2)) u_b (
    .clk(clk), .rst_n(rst_n), .i_start(b_start), .o_busy(b_busy), .o_done(b_done),
    .io_bus(b_if)
  );

  // Kernel models: fixed 2-cycle valid pipeline, flushed by reset.
  logic [1:0] a_pipe, b_pipe;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_pipe <= '0;
      b_pipe <= '0;
    end else begin
      a_pipe <= {a_pipe[0], a_if.o_k_valid};
      b_pipe <= {b_pipe[0], b_if.o_k_valid};
    end
  end
  assign a_if.i_k_valid = a_pipe[1];
  assign b_if.i_k_valid = b_pipe[1];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0, errors = 0;
  int q_addr[$];
  int q_iss[$];
  int n_wr, n_iss, n_done, done_cyc;
  int b_iss = 0, b_wr = 0, b_ndone = 0, b_wr_cyc = 0, b_done_cyc = 0;
  int w_delay = 1;
  bit win_rand = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Handshake responders, updated just after each rising edge.
  initial begin
    int w_cnt = 0;
    a_if.i_w_ack = 1'b0;
    a_if.i_win_ack = 1'b0;
    b_if.i_w_ack = 1'b0;
    b_if.i_win_ack = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (a_if.o_w_req) begin
        a_if.i_w_ack = (w_cnt == w_delay);
        w_cnt++;
      end else begin
        a_if.i_w_ack = 1'b0;
        w_cnt = 0;
      end
      a_if.i_win_ack = win_rand ? 1'($urandom_range(0, 1)) : 1'b1;
      b_if.i_w_ack = b_if.o_w_req;
    end
  end

  // Monitor for instance A.
  always @(negedge clk) begin
    if (rst_n) begin
      if (a_if.o_k_valid) begin
        check("issue_needs_ack", int'(a_if.i_win_ack), 1);
        if (q_iss.size() == 0) check("issue_unexpected", 1, 0);
        else check("issue_pos", int'(a_if.o_win_row) * 16 + int'(a_if.o_win_col),
                   q_iss.pop_front());
        n_iss++;
      end
      if (a_if.o_wr_en) begin
        if (q_addr.size() == 0) check("write_unexpected", 1, 0);
        else check("wr_addr", int'(a_if.o_wr_addr), q_addr.pop_front());
        n_wr++;
      end
      if (a_if.o_w_req) begin
        check("no_win_during_wload", int'(a_if.o_win_req), 0);
        check("w_ch_vs_writes", int'(a_if.o_w_ch), n_wr / 9);
      end
      if (a_done) begin
        n_done++;
        done_cyc = cyc;
      end
    end
  end

  // Monitor for instance B.
  always @(negedge clk) begin
    if (rst_n) begin
      if (b_if.o_k_valid) begin
        check("b_issue_pos", int'(b_if.o_win_row) * 16 + int'(b_if.o_win_col), 0);
        b_iss++;
      end
      if (b_if.o_wr_en) begin
        check("b_wr_addr", int'(b_if.o_wr_addr), 0);
        b_wr++;
        b_wr_cyc = cyc;
      end
      if (b_done) begin
        b_ndone++;
        b_done_cyc = cyc;
      end
    end
  end

  task automatic load_expect();
    q_addr.delete();
    q_iss.delete();
    n_wr = 0;
    n_iss = 0;
    n_done = 0;
    for (int ch = 0; ch < 2; ch++)
      for (int r = 0; r < 3; r++)
        for (int c = 0; c < 3; c++) begin
          q_iss.push_back(r * 16 + c);
          q_addr.push_back(ch * 9 + r * 3 + c);
        end
  endtask

  // exp_dt: cycles from the start-pulse cycle to the o_done cycle; -1 skips that check.
  task automatic run_a(input int dly, input bit rnd, input bit poke, input int exp_dt);
    int st_cyc;
    int t;
    load_expect();
    w_delay = dly;
    win_rand = rnd;
    @(posedge clk); #1;
    a_start = 1'b1;
    st_cyc = cyc;
    @(posedge clk); #1;
    a_start = 1'b0;
    check("busy_after_start", int'(a_busy), 1);
    t = 0;
    while (n_done == 0 && t < 2000) begin
      @(posedge clk); #1;
      t++;
      a_start = (poke && t == 5) ? 1'b1 : 1'b0;
    end
    a_start = 1'b0;
    check("done_seen", n_done, 1);
    if (exp_dt >= 0) check("done_latency", done_cyc - st_cyc, exp_dt);
    repeat (3) @(posedge clk);
    #1;
    check("done_once", n_done, 1);
    check("busy_low_after", int'(a_busy), 0);
    check("write_count", n_wr, 18);
    check("issue_count", n_iss, 18);
    check("addr_queue_drained", q_addr.size(), 0);
    win_rand = 1'b0;
  endtask

  task automatic reset_mid_run();
    int t;
    load_expect();
    w_delay = 1;
    win_rand = 1'b0;
    @(posedge clk); #1;
    a_start = 1'b1;
    @(posedge clk); #1;
    a_start = 1'b0;
    t = 0;
    while (!(n_iss == 3 && a_if.o_k_valid) && t < 100) begin
      @(posedge clk); #1;
      t++;
    end
    check("reached_4th_issue", n_iss, 3);
    #1;
    rst_n = 1'b0;
    #1;
    check("rst_k_valid", int'(a_if.o_k_valid), 0);
    check("rst_win_req", int'(a_if.o_win_req), 0);
    check("rst_busy", int'(a_busy), 0);
    check("rst_wr_en", int'(a_if.o_wr_en), 0);
    check("rst_wr_addr", int'(a_if.o_wr_addr), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    run_a(1, 1'b0, 1'b0, 27);
  endtask

  initial begin
    #3;
    check("reset_busy", int'(a_busy), 0);
    check("reset_done", int'(a_done), 0);
    check("reset_w_req", int'(a_if.o_w_req), 0);
    check("reset_win_req", int'(a_if.o_win_req), 0);
    check("reset_wr_addr", int'(a_if.o_wr_addr), 0);
    check("reset_b_busy", int'(b_busy), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    run_a(1, 1'b0, 1'b0, 27);   // acks tied: back-to-back windows
    run_a(1, 1'b1, 1'b0, -1);   // random window acks
    run_a(5, 1'b0, 1'b0, 35);   // slow weight ack
    run_a(1, 1'b0, 1'b1, 27);   // stray start during RUN
    reset_mid_run();

    // Single-position map on instance B.
    @(posedge clk); #1;
    b_start = 1'b1;
    @(posedge clk); #1;
    b_start = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    check("b_issue_count", b_iss, 1);
    check("b_write_count", b_wr, 1);
    check("b_done_count", b_ndone, 1);
    check("b_done_after_write", b_done_cyc - b_wr_cyc, 1);
    check("b_busy_low", int'(b_busy), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cnn_conv_ctrl.md
Name: cnn_conv_ctrl

Overview:
- Sequencer for one cnn_kernel instance: walks every valid (stride-1, no padding) output position of an IH x IW feature map, once per output channel.
- Per channel: requests that channel's weight set, then issues one window per accepted handshake, and drives the kernel's i_valid.
- Counts kernel o_valid pulses and generates output-buffer write addresses.
- Reports busy/done to the layer-level top.

Parameters:
- IW, 8, input feature map width (>= KW)
- IH, 8, input feature map height (>= KH)
- KW, 3, kernel width
- KH, 3, kernel height
- OCH, 4, number of output channels (weight sets)
- K_LAT, 2, kernel latency from i_valid to o_valid (cnn_kernel DELAY)
- Derived localparams: OW=IW-KW+1, OH=IH-KH+1, NPOS=OW*OH, NOUT=NPOS*OCH, OA_BW=$clog2(NOUT), CH_BW=$clog2(OCH) (min 1), R_BW=$clog2(OH), C_BW=$clog2(OW) (each min 1)

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- i_start  in  1  one-cycle start pulse; ignored unless IDLE
- o_busy  out  1  high from the cycle after an accepted start until DONE
- o_done  out  1  one-cycle pulse when the last result is written
- o_w_req  out  1  weight-set load request (level)
- o_w_ch  out  CH_BW  channel whose weights are requested
- i_w_ack  in  1  weights present on kernel i_weight from this cycle until the next o_w_req
- o_win_req  out  1  window request (level)
- o_win_row  out  R_BW  top-left row of requested window
- o_win_col  out  C_BW  top-left column of requested window
- i_win_ack  in  1  window data on kernel i_fmap this cycle
- o_k_valid  out  1  to kernel i_valid; equals o_win_req & i_win_ack (combinational)
- i_k_valid  in  1  from kernel o_valid
- o_wr_en  out  1  output-buffer write strobe; equals i_k_valid while in RUN/DRAIN
- o_wr_addr  out  OA_BW  ch*NPOS + row*OW + col of the result being written

Behaviour:
- Reset (async assert, sync deassert by the top): state=IDLE; all counters 0; o_busy, o_done, o_w_req, o_win_req = 0; o_wr_addr = 0.
- FSM states: IDLE, LOAD_W, RUN, DRAIN, DONE.
  - IDLE + i_start -> LOAD_W; ch=0, row=col=0, wr_cnt=0.
  - LOAD_W: o_w_req=1, o_w_ch=ch. On i_w_ack -> RUN (next cycle).
  - RUN: o_win_req=1. On each i_win_ack, advance col; at col==OW-1 wrap to 0 and increment row. The ack at row==OH-1, col==OW-1 -> DRAIN; o_win_req drops the next cycle.
  - DRAIN: o_win_req=0. When the channel write count reaches NPOS (including a write in the current cycle), either go to LOAD_W with ch+1, row=col=0, or, if ch==OCH-1, go to DONE.
  - DONE: o_done=1 for exactly one cycle -> IDLE.
- i_win_ack may be held high continuously: one window per cycle, 9 issues in 9 consecutive cycles for a 3x3 output. i_win_ack outside RUN is ignored.
- Write path: a separate write counter (wr_pos, wr_ch) advances on each i_k_valid. o_wr_addr = wr_ch*NPOS + wr_pos. No backpressure: every i_k_valid is written in its own cycle.
- In-flight issues never exceed K_LAT. Weights are never changed (no o_w_req) while the kernel holds an unwritten result of the current channel; DRAIN enforces this.
- o_busy is 1 in LOAD_W, RUN, DRAIN and DONE.
- i_start while busy: ignored, no effect on counters.
- i_k_valid in IDLE: ignored, counter unchanged (o_wr_en=0).
- Reset mid-run: immediate return to IDLE. The kernel pipeline is flushed by the same reset domain at the top.
- Degenerate OW=1 or OH=1: column/row wrap happens every issue; no special case needed.

Decomposition:
- Shared package cnn_pkg: state encoding (IDLE=0..DONE=4, 3 bits), the K_LAT default constant, and a clog2-min1 width function reused by other cnn_core controllers.
- One natural sub-module: cnn_pos_counter (row/col wrap counter with inc, clear, last flag). It is instantiated twice: issue side and write side (write side as a flat pos counter plus ch).

Test Plan:
- IW=IH=5, KW=KH=3, OCH=2, i_w_ack one cycle after req, i_win_ack tied 1, kernel model latency 2: o_k_valid high 9 consecutive cycles per channel; 18 writes with addrs 0..17 in order; o_done exactly once; o_busy low after.
- Same config, i_win_ack random 50%: issue order (row,col) = (0,0),(0,1),(0,2),(1,0)...(2,2); no o_k_valid without ack; write addrs still 0..17 in order.
- i_w_ack delayed 5 cycles: o_w_req held, o_win_req=0 throughout; o_w_ch=1 only after all 9 channel-0 writes complete.
- i_start pulsed during RUN: count, addresses and done timing identical to the unperturbed run.
- rst_n asserted mid-RUN at the 4th issue: outputs 0 that cycle asynchronously. Restart after release produces the full 0..17 sequence.
- IW=KW=3, IH=KH=3, OCH=1 (single position): one issue, one write to addr 0, o_done 1 cycle after the write cycle.
